// File: rtl/alu_byte_sequencer.sv
// Multi-byte ALU sequencer: feeds an 8-bit ALU one byte per cycle, LSB first, chaining carry.
// Latency WIDTH_BYTES cycles from accept to rsp_valid; holds the response until rsp_ready.
// Optional `ALU_SEQ_PIPE_EN: accept the next request on the response handshake cycle.
module alu_byte_sequencer #(
    parameter int WIDTH_BYTES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [8*WIDTH_BYTES-1:0]   i_req_a,
    input  logic [8*WIDTH_BYTES-1:0]   i_req_b,
    input  logic [3:0]                 i_req_sel,
    input  logic                       i_req_mode,
    input  logic                       i_req_cin,
    output logic [7:0]                 o_alu_a,
    output logic [7:0]                 o_alu_b,
    output logic                       o_alu_cf_in,
    output logic [3:0]                 o_alu_sel,
    output logic                       o_alu_mode,
    input  logic [7:0]                 i_alu_out,
    input  logic                       i_alu_cf,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [8*WIDTH_BYTES-1:0]   o_rsp_result,
    output logic                       o_rsp_cf,
    output logic                       o_rsp_zf,
    output logic                       o_rsp_nf
);

    localparam int IW = (WIDTH_BYTES > 1) ? $clog2(WIDTH_BYTES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef ALU_SEQ_PIPE_EN
    localparam logic PIPE_EN = 1'b1;
`else
    localparam logic PIPE_EN = 1'b0;
`endif

    logic [1:0]                  r_state;
    logic [IW-1:0]               r_idx;
    logic [WIDTH_BYTES-1:0][7:0] r_a;
    logic [WIDTH_BYTES-1:0][7:0] r_b;
    logic [WIDTH_BYTES-1:0][7:0] r_result;
    logic [3:0]                  r_sel;
    logic                        r_mode;
    logic                        r_cf;
    logic                        r_rsp_cf;
    logic                        r_zf;

    logic                        w_accept;
    logic                        w_rsp_hs;
    logic                        w_last;
    logic [WIDTH_BYTES-1:0][7:0] w_next_result;

    always_comb begin
        o_req_ready = (r_state == ST_IDLE) || (PIPE_EN && (r_state == ST_DONE) && i_rsp_ready);
        w_accept    = i_req_valid && o_req_ready;
        w_rsp_hs    = (r_state == ST_DONE) && i_rsp_ready;
        w_last      = (r_idx == IW'(WIDTH_BYTES - 1));
        // Result as it will look after this RUN edge; the zero flag is taken from it on the last byte.
        w_next_result        = r_result;
        w_next_result[r_idx] = i_alu_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_sel    <= '0;
            r_mode   <= 1'b0;
            r_cf     <= 1'b0;
            r_rsp_cf <= 1'b0;
            r_zf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= ST_RUN;
                r_idx   <= '0;
                r_a     <= i_req_a;
                r_b     <= i_req_b;
                r_sel   <= i_req_sel;
                r_mode  <= i_req_mode;
                r_cf    <= i_req_cin;
            end else if (w_rsp_hs) begin
                r_state <= ST_IDLE;
            end

            if (r_state == ST_RUN) begin
                r_result[r_idx] <= i_alu_out;
                r_cf            <= i_alu_cf;
                if (w_last) begin
                    r_state  <= ST_DONE;
                    r_rsp_cf <= i_alu_cf;
                    r_zf     <= ~|w_next_result;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_alu_a      = r_a[r_idx];
    assign o_alu_b      = r_b[r_idx];
    assign o_alu_cf_in  = r_cf;
    assign o_alu_sel    = r_sel;
    assign o_alu_mode   = r_mode;

    assign o_rsp_valid  = (r_state == ST_DONE);
    assign o_rsp_result = r_result;
    assign o_rsp_cf     = r_rsp_cf;
    assign o_rsp_zf     = r_zf;
    assign o_rsp_nf     = r_result[WIDTH_BYTES-1][7];

endmodule
